fp_mul_scheduler: RTL and testbench
===================================

// Module: fp_mul_scheduler
// PURPOSE
//   Round-robin scheduler that shares one pipelined fp_mul instance among NUM_REQ requesters.
//   Used in the final adder path so the x*x^2 products (formerly one multiplier per context) run on a single multiplier.
//   Tags each issued operation and routes each product back to its requester with a one-hot valid pulse.
// PARAMETERS
//   FLOAT_DATA_WIDTH  32  IEEE-754 single operand/result width
//   NUM_REQ           4   number of requesters (2..8)
//   MUL_LATENCY       4   fp_mul latency in clk_en-qualified cycles (>=1)
//   TAG_WIDTH         2   clog2(NUM_REQ), derived; do not override
// PORTS
//   clk           in   1                     clock
//   rst           in   1                     asynchronous reset, active-low (0 = reset)
//   clk_en        in   1                     global enable; 0 freezes all state
//   req           in   NUM_REQ               per-requester request, held until granted
//   op_a          in   NUM_REQ*FLOAT_DATA_WIDTH  flat operand A, requester i at [i*32 +: 32]
//   op_b          in   NUM_REQ*FLOAT_DATA_WIDTH  flat operand B, same packing
//   grant         out  NUM_REQ               one-hot, 1 cycle: operands of that requester taken
//   result        out  FLOAT_DATA_WIDTH      product, shared bus
//   result_valid  out  NUM_REQ               one-hot, 1 cycle: result belongs to requester i
//   busy          out  1                     any grant or operation in flight
//   mul_aclr      out  1                     to fp_mul aclr (= ~rst)
//   mul_clk_en    out  1                     to fp_mul clk_en (= clk_en)
//   mul_dataa     out  FLOAT_DATA_WIDTH      registered operand A to fp_mul
//   mul_datab     out  FLOAT_DATA_WIDTH      registered operand B to fp_mul
//   mul_result    in   FLOAT_DATA_WIDTH      fp_mul result
// BEHAVIOUR
//   - Reset (rst=0, async): grant=0, result_valid=0, result=0, mul_dataa/b=0, busy=0; tag pipe cleared; priority pointer=0.
//   - clk_en=0: every register holds (outputs included). Consumers qualify grant/result_valid with clk_en.
//   - Issue, each clk_en edge: eligible = req & ~grant (the requester granted this cycle is masked).
//     Winner = first eligible at or after pointer, wrapping mod NUM_REQ.
//     On a winner k: grant<=onehot(k), mul_dataa/b<=op_a/op_b[k], pointer<=(k+1)%NUM_REQ. No eligible: grant<=0, pointer holds.
//   - Requester rule: drop req (or present new operands) in the cycle grant[i] is high.
//   - Issue rate: up to 1 op/cycle across requesters, 1 op/2 cycles per requester.
//   - Tag pipe: MUL_LATENCY-stage shift of {valid,tag}, advanced only on clk_en; stage 0 loaded with {|grant, k}.
//   - Retire: when the tail is valid, result<=mul_result and result_valid<=onehot(tag); otherwise result_valid<=0 and result holds.
//   - Latency: grant high in cycle c -> result_valid in cycle c+MUL_LATENCY+1 (clk_en=1 throughout).
//     Each clk_en=0 cycle adds exactly one cycle.
//   - Ordering: results return in issue order. No backpressure; consumers must accept result_valid.
//   - busy = |grant | any tag-pipe valid.
//   - Reset mid-operation discards in-flight ops: no result_valid after release until a new grant.
//   - Simultaneous req change and grant: the arbiter samples req at the edge; a req rising in the grant cycle
//     of another requester competes at the next edge.
// STRUCTURE
//   - Shared package final_adder_pkg: FLOAT_DATA_WIDTH, MUL_LATENCY default, clog2 function, onehot helper.
//   - Sub-module rr_arbiter (NUM_REQ; eligible, pointer -> winner one-hot + index, any).
//   - Tag pipe and operand mux stay in this module.
//   - fp_mul is instantiated by the parent, not here.
// TESTING (bench uses a behavioural fp_mul model with MUL_LATENCY stages)
//   1. req=0001, op_a0=0x40000000, op_b0=0x40400000 -> grant=0001 at c; result=0x40C00000, result_valid=0001 at c+5.
//   2. req=1111 each held to grant -> grants 0001,0010,0100,1000 on 4 consecutive cycles;
//      result_valid in the same order on cycles c+5..c+8.
//   3. req0,req2 re-raised every cycle after grant -> grants alternate 0001,0100,0001,0100; never two 0001 in a row.
//   4. One op in flight, clk_en=0 for 3 cycles -> result_valid at c+8, value unchanged, no duplicate pulse.
//   5. Two ops in flight, rst=0 for 1 cycle -> outputs 0 immediately; no result_valid for 10 cycles;
//      next req=1111 grants requester 0 first.
//   6. Re-run 1-3 with NUM_REQ=2, MUL_LATENCY=1: latency c+2; grants alternate 01,10.

Source files
------------

// File: rtl/final_adder_pkg.sv
// Shared constants and small helpers for the final adder datapath.
package final_adder_pkg;

  localparam int DEFAULT_FLOAT_DATA_WIDTH = 32;
  localparam int DEFAULT_MUL_LATENCY      = 4;
  localparam int MAX_REQ                  = 8;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned index);
    return MAX_REQ'(1) << index;
  endfunction

endpackage

// File: rtl/fp_mul_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the pointer.
module rr_arbiter
  import final_adder_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  localparam int TAG_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   eligible,
  input  logic [TAG_WIDTH-1:0] pointer,
  output logic [NUM_REQ-1:0]   winner_oh,
  output logic [TAG_WIDTH-1:0] winner_idx,
  output logic                 any_eligible
);

  localparam logic [TAG_WIDTH:0] NUM_REQ_W = (TAG_WIDTH+1)'(NUM_REQ);

  always_comb begin
    logic [TAG_WIDTH:0] cand;
    winner_oh    = '0;
    winner_idx   = '0;
    any_eligible = 1'b0;
    cand         = '0;
    // One extra bit holds pointer+i before the wrap back into 0..NUM_REQ-1.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, pointer} + (TAG_WIDTH+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!any_eligible && eligible[cand[TAG_WIDTH-1:0]]) begin
        any_eligible = 1'b1;
        winner_idx   = cand[TAG_WIDTH-1:0];
      end
    end
    if (any_eligible) winner_oh = NUM_REQ'(onehot(int'(winner_idx)));
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one pipelined fp_mul among NUM_REQ requesters; a tag pipe that tracks
// the multiplier latency routes each product back with a one-hot valid pulse.
module fp_mul_scheduler
  import final_adder_pkg::*;
#(
  parameter  int FLOAT_DATA_WIDTH = DEFAULT_FLOAT_DATA_WIDTH,
  parameter  int NUM_REQ          = 4,
  parameter  int MUL_LATENCY      = DEFAULT_MUL_LATENCY,
  localparam int TAG_WIDTH        = clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clk_en,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] op_a,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [FLOAT_DATA_WIDTH-1:0]         result,
  output logic [NUM_REQ-1:0]                  result_valid,
  output logic                                busy,
  output logic                                mul_aclr,
  output logic                                mul_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0]         mul_dataa,
  output logic [FLOAT_DATA_WIDTH-1:0]         mul_datab,
  input  logic [FLOAT_DATA_WIDTH-1:0]         mul_result
);

  localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]                    grant_q, grant_d;
  logic [TAG_WIDTH-1:0]                  grant_idx_q, grant_idx_d;
  logic [TAG_WIDTH-1:0]                  ptr_q, ptr_d;
  logic [FLOAT_DATA_WIDTH-1:0]           dataa_q, dataa_d;
  logic [FLOAT_DATA_WIDTH-1:0]           datab_q, datab_d;
  logic [FLOAT_DATA_WIDTH-1:0]           result_q, result_d;
  logic [NUM_REQ-1:0]                    result_valid_q, result_valid_d;
  logic [MUL_LATENCY-1:0]                pipe_valid_q, pipe_valid_d;
  logic [MUL_LATENCY-1:0][TAG_WIDTH-1:0] pipe_tag_q, pipe_tag_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   winner_oh;
  logic [TAG_WIDTH-1:0] winner_idx;
  logic                 winner_any;

  // The requester granted this cycle is still presenting stale operands.
  assign eligible = req & ~grant_q;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arbiter (
    .eligible    (eligible),
    .pointer     (ptr_q),
    .winner_oh   (winner_oh),
    .winner_idx  (winner_idx),
    .any_eligible(winner_any)
  );

  always_comb begin
    grant_d        = grant_q;
    grant_idx_d    = grant_idx_q;
    ptr_d          = ptr_q;
    dataa_d        = dataa_q;
    datab_d        = datab_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    pipe_valid_d   = pipe_valid_q;
    pipe_tag_d     = pipe_tag_q;
    if (clk_en) begin
      grant_d     = winner_oh;
      grant_idx_d = winner_idx;
      if (winner_any) begin
        ptr_d = (winner_idx == LAST_IDX) ? '0 : winner_idx + TAG_WIDTH'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (winner_oh[i]) begin
            dataa_d = op_a[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
            datab_d = op_b[i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
          end
        end
      end
      // Stage 0 follows the registered grant, i.e. the cycle the operands reach fp_mul.
      pipe_valid_d[0] = |grant_q;
      pipe_tag_d[0]   = grant_idx_q;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pipe_valid_d[i] = pipe_valid_q[i-1];
        pipe_tag_d[i]   = pipe_tag_q[i-1];
      end
      result_valid_d = '0;
      if (pipe_valid_q[MUL_LATENCY-1]) begin
        result_d       = mul_result;
        result_valid_d = NUM_REQ'(onehot(int'(pipe_tag_q[MUL_LATENCY-1])));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q        <= '0;
      grant_idx_q    <= '0;
      ptr_q          <= '0;
      dataa_q        <= '0;
      datab_q        <= '0;
      result_q       <= '0;
      result_valid_q <= '0;
      pipe_valid_q   <= '0;
      pipe_tag_q     <= '0;
    end else begin
      grant_q        <= grant_d;
      grant_idx_q    <= grant_idx_d;
      ptr_q          <= ptr_d;
      dataa_q        <= dataa_d;
      datab_q        <= datab_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      pipe_valid_q   <= pipe_valid_d;
      pipe_tag_q     <= pipe_tag_d;
    end
  end

  assign grant        = grant_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (|grant_q) | (|pipe_valid_q);
  assign mul_aclr     = ~rst;
  assign mul_clk_en   = clk_en;
  assign mul_dataa    = dataa_q;
  assign mul_datab    = datab_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: a 4-requester/latency-4 instance and a
// 2-requester/latency-1 instance, each fed by a behavioural fp_mul pipeline.
module tb_fp_mul_scheduler;

  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F9  = 32'h41100000;
  localparam logic [31:0] F12 = 32'h41400000;
  localparam logic [31:0] F15 = 32'h41700000;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0]   req1;
  logic [127:0] op_a1, op_b1;
  logic [3:0]   grant1, rv1;
  logic [31:0]  result1, dataa1, datab1, mres1;
  logic         busy1, aclr1, clken1;

  logic [1:0]   req2;
  logic [63:0]  op_a2, op_b2;
  logic [1:0]   grant2, rv2;
  logic [31:0]  result2, dataa2, datab2, mres2;
  logic         busy2, aclr2, clken2;

  fp_mul_scheduler #(.FLOAT_DATA_WIDTH(32), .NUM_REQ(4), .MUL_LATENCY(4)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req1), .op_a(op_a1), .op_b(op_b1),
    .grant(grant1), .result(result1), .result_valid(rv1), .busy(busy1),
    .mul_aclr(aclr1), .mul_clk_en(clken1), .mul_dataa(dataa1), .mul_datab(datab1),
    .mul_result(mres1)
  );

  fp_mul_scheduler #(.FLOAT_DATA_WIDTH(32), .NUM_REQ(2), .MUL_LATENCY(1)) dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req2), .op_a(op_a2), .op_b(op_b2),
    .grant(grant2), .result(result2), .result_valid(rv2), .busy(busy2),
    .mul_aclr(aclr2), .mul_clk_en(clken2), .mul_dataa(dataa2), .mul_datab(datab2),
    .mul_result(mres2)
  );

  // Exact for the small normal values used here; the bits below 23 are dropped.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  logic [31:0] m1_pipe [4];
  always @(posedge clk or posedge aclr1) begin
    if (aclr1) begin
      for (int i = 0; i < 4; i++) m1_pipe[i] <= '0;
    end else if (clken1) begin
      m1_pipe[0] <= fmul(dataa1, datab1);
      for (int i = 1; i < 4; i++) m1_pipe[i] <= m1_pipe[i-1];
    end
  end
  assign mres1 = m1_pipe[3];

  logic [31:0] m2_pipe;
  always @(posedge clk or posedge aclr2) begin
    if (aclr2) m2_pipe <= '0;
    else if (clken2) m2_pipe <= fmul(dataa2, datab2);
  end
  assign mres2 = m2_pipe;

  typedef struct {
    bit          first;
    bit          sel;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  rv;
    logic [31:0] result;
    bit          busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit first, bit sel, logic [3:0] req, logic [3:0] grant,
                              logic [3:0] rv, logic [31:0] result, bit busy);
    vec_t v;
    v.first = first; v.sel = sel; v.req = req; v.grant = grant;
    v.rv = rv; v.result = result; v.busy = busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst  = 1'b0;
    req1 = '0;
    req2 = '0;
    #1;
    checkOutput("reset grant1", {28'd0, grant1}, 32'd0);
    checkOutput("reset rv1", {28'd0, rv1}, 32'd0);
    checkOutput("reset result1", result1, 32'd0);
    checkOutput("reset busy1", {31'd0, busy1}, 32'd0);
    checkOutput("reset dataa1", dataa1, 32'd0);
    checkOutput("reset aclr1", {31'd0, aclr1}, 32'd1);
    checkOutput("reset grant2", {30'd0, grant2}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("release aclr1", {31'd0, aclr1}, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.sel) begin
      req1 = '0;
      req2 = v.req[1:0];
    end else begin
      req1 = v.req;
      req2 = '0;
    end
    step();
  endtask

  task automatic checkRow(input int idx, input vec_t v);
    logic [3:0] g, r;
    logic [31:0] res;
    logic b;
    g   = v.sel ? {2'b00, grant2} : grant1;
    r   = v.sel ? {2'b00, rv2} : rv1;
    res = v.sel ? result2 : result1;
    b   = v.sel ? busy2 : busy1;
    checkOutput($sformatf("row%0d grant", idx), {28'd0, g}, {28'd0, v.grant});
    checkOutput($sformatf("row%0d result_valid", idx), {28'd0, r}, {28'd0, v.rv});
    checkOutput($sformatf("row%0d busy", idx), {31'd0, b}, {31'd0, v.busy});
    if (v.rv != 4'd0) checkOutput($sformatf("row%0d result", idx), res, v.result);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst    = 1'b0;
    clk_en = 1'b1;
    req1   = '0;
    req2   = '0;
    op_a1  = {F5, F4, F3, F2};
    op_b1  = {F3, F3, F3, F3};
    op_a2  = {F3, F2};
    op_b2  = {F3, F3};

    // Single request, latency 5.
    vecs.push_back(mk(1, 0, 4'b0001, 4'b0001, 4'b0000, 32'd0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001, F6, 0));
    // All four requesting, each dropped when granted.
    vecs.push_back(mk(1, 0, 4'b1111, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b1110, 4'b0010, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b1100, 4'b0100, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b1000, 4'b1000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0010, F9, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0100, F12, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b1000, F15, 0));
    // Requesters 0 and 2 continuously requesting alternate.
    vecs.push_back(mk(1, 0, 4'b0101, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0101, 4'b0100, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0101, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0101, 4'b0100, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0100, F12, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0100, F12, 0));
    // Lone requester holding req: one grant every other cycle.
    vecs.push_back(mk(1, 0, 4'b0001, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0001, F6, 0));
    // Two-requester, latency-1 instance: same patterns, latency 2.
    vecs.push_back(mk(1, 1, 4'b0001, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0001, F6, 0));
    vecs.push_back(mk(1, 1, 4'b0011, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0010, 4'b0010, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0010, F9, 0));
    vecs.push_back(mk(1, 1, 4'b0011, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 4'b0010, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 4'b0001, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 4'b0010, 4'b0010, F9, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0010, F9, 0));
    vecs.push_back(mk(1, 1, 4'b0001, 4'b0001, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0001, 4'b0001, F6, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 32'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0001, F6, 0));

    foreach (vecs[i]) begin
      if (vecs[i].first) resetDut();
      applyStimulus(vecs[i]);
      checkRow(i, vecs[i]);
    end

    // clk_en low right after a grant freezes the grant pulse itself.
    resetDut();
    req1 = 4'b0001;
    step();
    checkOutput("freeze grant issued", {28'd0, grant1}, 32'h1);
    req1   = 4'b0000;
    clk_en = 1'b0;
    step();
    checkOutput("freeze grant held", {28'd0, grant1}, 32'h1);
    checkOutput("freeze mul_clk_en", {31'd0, clken1}, 32'd0);
    clk_en = 1'b1;
    step();
    checkOutput("freeze grant released", {28'd0, grant1}, 32'h0);

    // Three clk_en=0 cycles with one op in flight push the result to c+8.
    resetDut();
    req1 = 4'b0001;
    step();
    checkOutput("stall grant", {28'd0, grant1}, 32'h1);
    req1 = 4'b0000;
    for (int j = 1; j <= 10; j++) begin
      clk_en = (j >= 2 && j <= 4) ? 1'b0 : 1'b1;
      step();
      checkOutput($sformatf("stall c+%0d result_valid", j), {28'd0, rv1},
                  (j == 8) ? 32'h1 : 32'h0);
      if (j == 8) checkOutput("stall result", result1, F6);
    end
    clk_en = 1'b1;

    // Reset with two ops in flight discards them and rewinds the pointer.
    resetDut();
    req1 = 4'b0011;
    step();
    checkOutput("abort grant0", {28'd0, grant1}, 32'h1);
    req1 = 4'b0010;
    step();
    checkOutput("abort grant1", {28'd0, grant1}, 32'h2);
    req1 = 4'b0000;
    step();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy1}, 32'd0);
    checkOutput("abort dataa", dataa1, 32'd0);
    checkOutput("abort datab", datab1, 32'd0);
    #9;
    rst = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      checkOutput($sformatf("abort c+%0d result_valid", j), {28'd0, rv1}, 32'h0);
    end
    req1 = 4'b1111;
    step();
    checkOutput("abort regrant", {28'd0, grant1}, 32'h1);
    req1 = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
